// File: rtl/darkbus_arbiter.sv
// Two-provider round-robin arbiter in front of one darkbus consumer.
// Optional transaction timeout is built when DARKBUS_ARB_TIMEOUT_EN is defined.
module darkbus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        m0_en,
    input  logic        m0_rw,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_valid,
    input  logic        m1_en,
    input  logic        m1_rw,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_valid,
    output logic        s_en,
    output logic        s_rw,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_valid,
    output logic [1:0]  gnt,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        busy, sel1, done, tmo_hit, other_en;
    logic [31:0] rdata;

    assign busy     = (state_q == BUSY);
    assign sel1     = gnt_q[1];
    assign done     = busy && (s_valid || tmo_hit);
    assign other_en = sel1 ? m0_en : m1_en;

    always_comb begin
        s_en    = 1'b0;
        s_rw    = 1'b0;
        s_be    = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (busy) begin
            s_en    = 1'b1;
            s_rw    = sel1 ? m1_rw    : m0_rw;
            s_be    = sel1 ? m1_be    : m0_be;
            s_addr  = sel1 ? m1_addr  : m0_addr;
            s_wdata = sel1 ? m1_wdata : m0_wdata;
        end
    end

    assign rdata    = !busy ? '0 : (tmo_hit ? 32'hDEAD_BEEF : s_rdata);
    assign m0_rdata = rdata;
    assign m1_rdata = rdata;
    assign m0_valid = done && gnt_q[0];
    assign m1_valid = done && gnt_q[1];
    assign gnt      = gnt_q;

    // The completing provider's en is ignored; only the other one can take over.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_en && (!m1_en || last_q)) begin
                    state_d = BUSY;
                    gnt_d   = 2'b01;
                end else if (m1_en) begin
                    state_d = BUSY;
                    gnt_d   = 2'b10;
                end
            end
            BUSY: begin
                if (done) begin
                    last_d = sel1;
                    if (other_en) begin
                        gnt_d = ~gnt_q;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

`ifdef DARKBUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;

    // Fires in the TIMEOUT-th BUSY cycle of a grant; a real s_valid wins.
    assign tmo_hit = busy && !s_valid && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        err_d     = err_q | tmo_hit;
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (!busy || done) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_darkbus_arbiter.sv
// Self-checking bench for darkbus_arbiter: directed vector table, reset and
// timeout sequences, then randomized traffic against a transaction-level model.
module tb_darkbus_arbiter;

`ifdef DARKBUS_ARB_TIMEOUT_EN
    localparam int TB_TMO = 16;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TB_TMO = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES;
    logic        m0_en, m0_rw, m1_en, m1_rw;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_valid, m1_valid;
    logic        s_en, s_rw;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_valid;
    logic [1:0]  gnt;
    logic        err;

    darkbus_arbiter #(.TIMEOUT(TB_TMO)) dut (
        .CLK(CLK), .RES(RES),
        .m0_en(m0_en), .m0_rw(m0_rw), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_valid(m0_valid),
        .m1_en(m1_en), .m1_rw(m1_rw), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_valid(m1_valid),
        .s_en(s_en), .s_rw(s_rw), .s_be(s_be), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_valid(s_valid),
        .gnt(gnt), .err(err)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Provider request registers (what each provider currently presents)
    bit          pen[2];
    logic        prw[2];
    logic [3:0]  pbe[2];
    logic [31:0] paddr[2];
    logic [31:0] pwdata[2];

    typedef struct {
        bit          e0;
        bit          e1;
        bit          sv;
        logic [31:0] rd;
        logic [1:0]  gnt;
        bit          v0;
        bit          v1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit e0, bit e1, bit sv, logic [31:0] rd,
                                logic [1:0] g, bit v0, bit v1);
        vec_t v;
        v.e0 = e0; v.e1 = e1; v.sv = sv; v.rd = rd;
        v.gnt = g; v.v0 = v0; v.v1 = v1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] exp_s(int own);
        if (own < 0) return '0;
        return 96'({1'b1, prw[own], pbe[own], paddr[own], pwdata[own]});
    endfunction

    task automatic drive(input logic sv, input logic [31:0] rd);
        m0_en = pen[0]; m0_rw = prw[0]; m0_be = pbe[0]; m0_addr = paddr[0]; m0_wdata = pwdata[0];
        m1_en = pen[1]; m1_rw = prw[1]; m1_be = pbe[1]; m1_addr = paddr[1]; m1_wdata = pwdata[1];
        s_valid = sv;
        s_rdata = rd;
    endtask

    task automatic check_cycle(input string tag, input int own, input bit v0, input bit v1,
                               input logic [31:0] rd_exp, input bit err_exp);
        logic [1:0] g;
        g = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        chk({tag, ".gnt"}, 96'(gnt), 96'(g));
        chk({tag, ".sbus"}, 96'({s_en, s_rw, s_be, s_addr, s_wdata}), exp_s(own));
        chk({tag, ".m0_valid"}, 96'(m0_valid), 96'(v0));
        chk({tag, ".m1_valid"}, 96'(m1_valid), 96'(v1));
        if (v0 || v1) begin
            chk({tag, ".m0_rdata"}, 96'(m0_rdata), 96'(rd_exp));
            chk({tag, ".m1_rdata"}, 96'(m1_rdata), 96'(rd_exp));
        end
        chk({tag, ".err"}, 96'(err), 96'(err_exp));
    endtask

    task automatic set_fixed();
        prw[0] = 1'b0; pbe[0] = 4'hF; paddr[0] = 32'h0000_0100; pwdata[0] = 32'h0;
        prw[1] = 1'b1; pbe[1] = 4'b0011; paddr[1] = 32'h8000_0004; pwdata[1] = 32'h0000_CAFE;
    endtask

    task automatic do_reset();
        pen[0] = 1'b0; pen[1] = 1'b0;
        RES = 1'b1;
        drive(1'b0, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RES = 1'b0;
    endtask

    // Transaction-level reference model state
    int own, last, busy_n;
    bit merr;
    bit pdone[2];

    initial begin
        set_fixed();
        pen[0] = 1'b0; pen[1] = 1'b0;
        RES = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF);
        #1;
        check_cycle("reset_during", -1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("reset_during.m0_rdata", 96'(m0_rdata), 96'h0);
        chk("reset_during.m1_rdata", 96'(m1_rdata), 96'h0);
        @(negedge CLK);
        @(negedge CLK);
        RES = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        check_cycle("reset_after", -1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Directed table: single read, spurious s_valid, m1 write, simultaneous
        // first requests, fairness, abandoned request.
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b01, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b01, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b01, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h12345678, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h55AA55AA, 2'b00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        2'b10, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h0BAD_F00D, 2'b10, 0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0001, 2'b01, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        2'b10, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0002, 2'b10, 0, 1));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0003, 2'b01, 1, 0));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0004, 2'b10, 0, 1));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0005, 2'b01, 1, 0));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0006, 2'b10, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0007, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        2'b00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b10, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hFEED_0001, 2'b10, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 0));

        foreach (vecs[i]) begin
            int o;
            @(negedge CLK);
            pen[0] = vecs[i].e0;
            pen[1] = vecs[i].e1;
            drive(vecs[i].sv, vecs[i].rd);
            #1;
            o = (vecs[i].gnt == 2'b01) ? 0 : ((vecs[i].gnt == 2'b10) ? 1 : -1);
            check_cycle($sformatf("vec%0d", i), o, vecs[i].v0, vecs[i].v1, vecs[i].rd, 1'b0);
        end

        // Reset in the middle of an m1 transaction, then both request
        @(negedge CLK);
        pen[0] = 1'b0; pen[1] = 1'b1;
        drive(1'b0, 32'h0);
        @(negedge CLK);
        #1;
        chk("midrst.gnt_before", 96'(gnt), 96'(2'b10));
        #2;
        RES = 1'b1;
        #1;
        chk("midrst.s_en_async", 96'(s_en), 96'h0);
        chk("midrst.gnt_async", 96'(gnt), 96'h0);
        @(negedge CLK);
        RES = 1'b0;
        pen[0] = 1'b1; pen[1] = 1'b1;
        drive(1'b0, 32'h0);
        #1;
        chk("midrst.gnt_idle", 96'(gnt), 96'h0);
        @(negedge CLK);
        #1;
        chk("midrst.gnt_m0_first", 96'(gnt), 96'(2'b01));
        do_reset();

`ifdef DARKBUS_ARB_TIMEOUT_EN
        // m0 read that the consumer never answers
        @(negedge CLK);
        pen[0] = 1'b1; pen[1] = 1'b0;
        drive(1'b0, 32'h0);
        for (int k = 1; k <= TB_TMO; k++) begin
            @(negedge CLK);
            drive(1'b0, 32'h1111_2222);
            #1;
            check_cycle($sformatf("tmo_busy%0d", k), 0, (k == TB_TMO), 1'b0,
                        32'hDEAD_BEEF, 1'b0);
        end
        @(negedge CLK);
        pen[0] = 1'b0; pen[1] = 1'b1;
        drive(1'b0, 32'h0);
        #1;
        check_cycle("tmo_after_idle", -1, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge CLK);
        drive(1'b1, 32'h0000_A5A5);
        #1;
        check_cycle("tmo_m1_served", 1, 1'b0, 1'b1, 32'h0000_A5A5, 1'b1);
        @(negedge CLK);
        pen[1] = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        check_cycle("tmo_err_sticky", -1, 1'b0, 1'b0, 32'h0, 1'b1);
        do_reset();
`endif

        // Randomized protocol-conforming traffic
        own = -1; last = 1; busy_n = 0; merr = 1'b0;
        pdone[0] = 1'b0; pdone[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        sv;
            logic [31:0] rd;
            bit          tmo, done;
            @(negedge CLK);
            for (int p = 0; p < 2; p++) begin
                if (pdone[p] || !pen[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pen[p]    = 1'b1;
                        prw[p]    = 1'($urandom_range(0, 1));
                        pbe[p]    = 4'($urandom);
                        paddr[p]  = $urandom;
                        pwdata[p] = $urandom;
                    end else begin
                        pen[p] = 1'b0;
                    end
                end
            end
            sv = (own >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            rd = $urandom;
            drive(sv, rd);
            #1;
            tmo  = TMO_EN && (own >= 0) && !sv && (busy_n + 1 == TB_TMO);
            done = (own >= 0) && (sv || tmo);
            check_cycle($sformatf("rnd%0d", cyc), own, done && own == 0, done && own == 1,
                        tmo ? 32'hDEAD_BEEF : rd, merr);
            pdone[0] = done && own == 0;
            pdone[1] = done && own == 1;
            if (own < 0) begin
                busy_n = 0;
                if (pen[0] && pen[1]) own = 1 - last;
                else if (pen[0])      own = 0;
                else if (pen[1])      own = 1;
            end else if (done) begin
                if (tmo) merr = 1'b1;
                last   = own;
                busy_n = 0;
                own    = pen[1 - own] ? 1 - own : -1;
            end else begin
                busy_n++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
